// File: rtl/cpu_trace_pkg.sv
// Shared constants and types for the CPU trace UART: frame layout, TX FSM
// state encoding and the captured record format.
package cpu_trace_pkg;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam int         FRAME_BYTES   = 9;
    localparam int         BITS_PER_BYTE = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] result;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Single-clock show-ahead FIFO for trace records; dout always presents the
// oldest entry, and push/pop are ignored when full/empty respectively.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             wr_en, rd_en;

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        level_d = level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; level/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/cpu_trace_uart.sv
// CPU trace observer: captures {Addr,Result} whenever Addr changes, buffers the
// records and streams each one out as a 9-byte 8N1 UART frame led by 0xA5.
module cpu_trace_uart
    import cpu_trace_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [31:0]                   Addr,
    input  logic [31:0]                   Result,
    input  logic                          Capture_en,
    output logic                          Tx,
    output logic                          Busy,
    output logic                          Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_level
);

    localparam int              BW        = $clog2(CLK_DIV);
    localparam int              FRAME_W   = FRAME_BYTES * 8;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [2:0]      DATA_LAST = 3'(BITS_PER_BYTE - 3);
    localparam logic [3:0]      BYTE_LAST = 4'(FRAME_BYTES - 1);

    tx_state_e          state_q, state_d;
    logic [BW-1:0]      baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [3:0]         byte_idx_q, byte_idx_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic               tx_q, tx_d;
    logic               overflow_q, overflow_d;
    logic [31:0]        prev_addr_q, prev_addr_d;

    logic       capture, fifo_pop, fifo_full, fifo_empty, bit_end;
    logic [7:0] cur_byte;
    trace_rec_t fifo_din, fifo_dout;

    assign capture  = Capture_en && (Addr != prev_addr_q);
    assign fifo_din = '{addr: Addr, result: Result};
    assign bit_end  = (baud_q == BAUD_LAST);
    assign cur_byte = shreg_q[FRAME_W-1 -: 8];

    trace_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_fifo (
        .clk   (Clock),
        .rst_n (Reset),
        .push  (capture),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (Fifo_level)
    );

    // NOTE: every _d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        shreg_d     = shreg_q;
        tx_d        = tx_q;
        fifo_pop    = 1'b0;
        prev_addr_d = Addr;
        overflow_d  = overflow_q || (capture && fifo_full);

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shreg_d    = {SYNC_BYTE, fifo_dout};
                    byte_idx_d = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_d    = 1'b0;
                baud_d  = '0;
                state_d = ST_START;
            end
            ST_START: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    bit_idx_d = '0;
                    tx_d      = cur_byte[0];
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    if (bit_idx_q == DATA_LAST) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = cur_byte[bit_idx_q + 3'd1];
                    end
                end
            end
            ST_STOP: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    if (byte_idx_q != BYTE_LAST) begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        shreg_d    = shreg_q << 8;
                        tx_d       = 1'b0;
                        state_d    = ST_START;
                    end else if (!fifo_empty) begin
                        // Reload straight into the start bit so frames abut with no idle bit.
                        fifo_pop   = 1'b1;
                        shreg_d    = {SYNC_BYTE, fifo_dout};
                        byte_idx_d = '0;
                        tx_d       = 1'b0;
                        state_d    = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            byte_idx_q  <= '0;
            shreg_q     <= '0;
            tx_q        <= 1'b1;
            overflow_q  <= 1'b0;
            prev_addr_q <= 32'hFFFF_FFFF;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            shreg_q     <= shreg_d;
            tx_q        <= tx_d;
            overflow_q  <= overflow_d;
            prev_addr_q <= prev_addr_d;
        end
    end

    assign Tx       = tx_q;
    assign Overflow = overflow_q;
    assign Busy     = (state_q != ST_IDLE) || (Fifo_level != '0);

endmodule

// File: tb/tb_cpu_trace_uart.sv
// Scoreboard bench for cpu_trace_uart: a record/transmitter model predicts frames,
// a UART receiver decodes Tx and compares each frame against the expected queue.
module tb_cpu_trace_uart;

    localparam int CLK_DIV   = 4;
    localparam int DEPTH     = 8;
    localparam int FRAME_CYC = 90 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cap_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] result = '0;
    logic        tx, busy, ovf;
    logic [3:0]  level;

    cpu_trace_uart #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .Clock      (clk),
        .Reset      (rst_n),
        .Addr       (addr),
        .Result     (result),
        .Capture_en (cap_en),
        .Tx         (tx),
        .Busy       (busy),
        .Overflow   (ovf),
        .Fifo_level (level)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] rec;
        int          fall;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] m_q[$];
    logic [31:0] m_prev = '1;
    bit          m_ovf = 1'b0;
    bit          m_active = 1'b0;
    int          m_end = 0;
    int          cyc = 0;
    int          m_pre;
    logic [63:0] m_rec;

    // The transmitter takes the oldest record whenever it is free: one cycle after
    // an idle pop Tx falls, and each frame occupies exactly FRAME_CYC cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            exp_q.delete();
            m_prev   = '1;
            m_ovf    = 1'b0;
            m_active = 1'b0;
        end else begin
            cyc++;
            m_pre = m_q.size();
            if (m_active && cyc == m_end) begin
                if (m_pre > 0) begin
                    m_rec = m_q.pop_front();
                    exp_q.push_back('{m_rec, cyc});
                    m_end = cyc + FRAME_CYC;
                end else begin
                    m_active = 1'b0;
                end
            end else if (!m_active && m_pre > 0) begin
                m_rec = m_q.pop_front();
                exp_q.push_back('{m_rec, cyc + 1});
                m_end    = cyc + 1 + FRAME_CYC;
                m_active = 1'b1;
            end
            if (cap_en && addr != m_prev) begin
                if (m_pre < DEPTH) m_q.push_back({addr, result});
                else m_ovf = 1'b1;
            end
            m_prev = addr;
        end
    end

    // ---------------- per-cycle status checks ----------------
    int peak = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("fifo_level", 72'(level), 72'(m_q.size()));
            check("overflow", 72'(ovf), 72'(m_ovf));
            check("busy", 72'(busy), 72'(m_active || m_q.size() != 0));
            if (int'(level) > peak) peak = int'(level);
        end
    end

    // ---------------- UART receiver / scoreboard monitor ----------------
    bit          rx_on = 1'b0;
    int          rx_s = 0;
    int          rx_nbytes = 0;
    int          frame_start = 0;
    int          frames_rx = 0;
    logic [7:0]  rx_byte = '0;
    logic [71:0] rx_frame = '0;
    exp_t        rx_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_on     = 1'b0;
            rx_nbytes = 0;
        end else if (!rx_on) begin
            if (tx == 1'b0) begin
                rx_on = 1'b1;
                rx_s  = 0;
                if (rx_nbytes == 0) frame_start = cyc;
            end
        end else begin
            rx_s++;
            if (rx_s % CLK_DIV == CLK_DIV / 2 && rx_s / CLK_DIV >= 1 && rx_s / CLK_DIV <= 8)
                rx_byte[rx_s / CLK_DIV - 1] = tx;
            if (rx_s == 9 * CLK_DIV + CLK_DIV / 2) begin
                check("stop_bit", 72'(tx), 72'(1));
                rx_on     = 1'b0;
                rx_frame  = {rx_frame[63:0], rx_byte};
                rx_nbytes++;
                if (rx_nbytes == 9) begin
                    rx_nbytes = 0;
                    frames_rx++;
                    check("frame_expected", 72'(exp_q.size() != 0), 72'(1));
                    if (exp_q.size() != 0) begin
                        rx_exp = exp_q.pop_front();
                        check("frame_data", rx_frame, {8'hA5, rx_exp.rec});
                        check("frame_start_cycle", 72'(frame_start), 72'(rx_exp.fall));
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (n < limit && (busy || exp_q.size() != 0 || rx_on)) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 72'(n < limit), 72'(1));
    endtask

    // ---------------- stimulus ----------------
    int  n, f0, bsum;

    initial begin
        // 1: reset
        repeat (3) @(negedge clk);
        check("reset_tx", 72'(tx), 72'(1));
        check("reset_busy", 72'(busy), 72'(0));
        check("reset_overflow", 72'(ovf), 72'(0));
        check("reset_level", 72'(level), 72'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_tx", 72'(tx), 72'(1));

        // 2: single record, latency and frame length
        cap_en = 1'b1;
        addr   = 32'h4;
        result = 32'hA;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx && n < 20);
        check("tx_fall_latency", 72'(n - 1), 72'(2));
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("frame_cycles", 72'(n), 72'(FRAME_CYC));
        wait_idle(100);
        check("case2_frames", 72'(frames_rx), 72'(1));

        // 3: static address produces one record only
        f0   = frames_rx;
        peak = 0;
        addr   = 32'h8;
        result = $urandom;
        repeat (50) @(negedge clk);
        check("case3_peak_level", 72'(peak), 72'(1));
        wait_idle(2000);
        check("case3_frames", 72'(frames_rx - f0), 72'(1));

        // 4: burst of ten records overflows by one
        f0   = frames_rx;
        peak = 0;
        for (int i = 0; i < 10; i++) begin
            addr   = 32'(4 * i);
            result = $urandom;
            @(negedge clk);
        end
        @(negedge clk);
        check("case4_overflow", 72'(ovf), 72'(1));
        check("case4_peak_level", 72'(peak), 72'(8));
        wait_idle(5000);
        check("case4_frames", 72'(frames_rx - f0), 72'(9));

        // 5: asynchronous reset during the third byte
        addr   = 32'h4;
        result = $urandom;
        @(negedge clk);
        addr = 32'd100;
        @(negedge clk);
        addr = 32'd200;
        n = 0;
        while (!(rx_on && rx_nbytes == 2 && rx_s >= 2 * CLK_DIV) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("case5_reached_byte3", 72'(n < 2000), 72'(1));
        check("case5_level_before", 72'(level), 72'(2));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("case5_rst_tx", 72'(tx), 72'(1));
        check("case5_rst_level", 72'(level), 72'(0));
        check("case5_rst_overflow", 72'(ovf), 72'(0));
        addr   = 32'h4;
        result = $urandom;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        f0 = frames_rx;
        repeat (3) @(negedge clk);
        wait_idle(2000);
        check("case5_frames", 72'(frames_rx - f0), 72'(1));

        // 6: disabled capture and re-enable with a static address
        f0     = frames_rx;
        cap_en = 1'b0;
        addr   = 32'h0;
        @(negedge clk);
        addr = 32'h4;
        @(negedge clk);
        addr = 32'h8;
        @(negedge clk);
        cap_en = 1'b1;
        bsum = 0;
        repeat (20) begin
            @(negedge clk);
            bsum = bsum | int'(busy);
        end
        check("case6_busy_quiet", 72'(bsum), 72'(0));
        check("case6_no_frames", 72'(frames_rx - f0), 72'(0));
        addr   = 32'd12;
        result = $urandom;
        repeat (3) @(negedge clk);
        wait_idle(2000);
        check("case6_frames", 72'(frames_rx - f0), 72'(1));

        // 7: randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cap_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) addr = $urandom & 32'hFFFF_FFFC;
            result = $urandom;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        wait_idle(20000);
        check("final_scoreboard_empty", 72'(exp_q.size()), 72'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
